// File: rtl/stream_cipher_pkg.sv
// ============================================================================
// stream_cipher_pkg : types and defaults shared by the stream cipher blocks
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_cipher_pkg;

    localparam int KEY_BYTES_DEFAULT  = 8;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    typedef logic [8*KEY_BYTES_DEFAULT-1:0] key_t;

    typedef enum logic [2:0] {
        IF_IDLE     = 3'd0,
        IF_LOAD_KEY = 3'd1,
        IF_STREAM   = 3'd2,
        IF_DRAIN    = 3'd3,
        IF_ERROR    = 3'd4
    } interface_state_t;

endpackage

`default_nettype wire

// File: rtl/byte_fifo.sv
// ============================================================================
// byte_fifo : first-word-fall-through byte FIFO, head shown combinationally
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_fifo
    import stream_cipher_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push;

    // A full FIFO still accepts a push when a real pop frees a slot this cycle.
    assign w_pop  = pop & (r_count != '0);
    assign w_push = push & ((r_count != FULL_COUNT) | w_pop);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == FULL_COUNT);
    assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/data_router.sv
// ============================================================================
// data_router : steers pulsed bytes into the key register or the data FIFO
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module data_router
    import stream_cipher_pkg::*;
#(
    parameter int KEY_BYTES  = KEY_BYTES_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [7:0]             input_byte_pulsed,
    input  logic                   is_key_pulsed,
    input  logic                   input_byte_pulse,
    input  logic                   err_clear,
    output logic [8*KEY_BYTES-1:0] key,
    output logic                   key_valid,
    output logic                   key_loaded_pulse,
    output logic [7:0]             data_byte,
    output logic                   data_valid,
    input  logic                   data_ready,
    output logic [CW-1:0]          fifo_count,
    output logic                   fifo_full,
    output logic                   err_overflow,
    output logic                   err_no_key
);

    localparam int IDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_BYTES - 1);

    logic [8*KEY_BYTES-1:0] r_key;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_key_valid;
    logic                   r_key_loaded_pulse;
    logic                   r_err_overflow;
    logic                   r_err_no_key;

    logic w_key_evt;
    logic w_data_evt;
    logic w_pop;
    logic w_push;
    logic w_no_key_evt;
    logic w_ovf_evt;
    logic w_fifo_empty;

    assign w_key_evt    = input_byte_pulse & is_key_pulsed;
    assign w_data_evt   = input_byte_pulse & ~is_key_pulsed;
    assign w_pop        = data_valid & data_ready;
    assign w_push       = w_data_evt & r_key_valid & (~fifo_full | w_pop);
    assign w_no_key_evt = w_data_evt & ~r_key_valid;
    assign w_ovf_evt    = w_data_evt & r_key_valid & fifo_full & ~w_pop;

    // Any key byte disqualifies the held key; only the final slot requalifies it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_key              <= '0;
            r_idx              <= '0;
            r_key_valid        <= 1'b0;
            r_key_loaded_pulse <= 1'b0;
        end else begin
            r_key_loaded_pulse <= 1'b0;
            if (w_key_evt) begin
                r_key[8*r_idx +: 8] <= input_byte_pulsed;
                if (r_idx == LAST_IDX) begin
                    r_idx              <= '0;
                    r_key_valid        <= 1'b1;
                    r_key_loaded_pulse <= 1'b1;
                end else begin
                    r_idx       <= r_idx + IDX_W'(1);
                    r_key_valid <= 1'b0;
                end
            end
        end
    end

    // A fresh error event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_err_overflow <= 1'b0;
            r_err_no_key   <= 1'b0;
        end else begin
            r_err_overflow <= (r_err_overflow & ~err_clear) | w_ovf_evt;
            r_err_no_key   <= (r_err_no_key & ~err_clear) | w_no_key_evt;
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_data_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (w_push),
        .push_data (input_byte_pulsed),
        .pop       (data_ready),
        .head      (data_byte),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (w_fifo_empty)
    );

    assign data_valid       = ~w_fifo_empty;
    assign key              = r_key;
    assign key_valid        = r_key_valid;
    assign key_loaded_pulse = r_key_loaded_pulse;
    assign err_overflow     = r_err_overflow;
    assign err_no_key       = r_err_no_key;

endmodule

`default_nettype wire

// File: tb/tb_data_router.sv
// ============================================================================
// tb_data_router : scoreboard bench for data_router
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_router;

    localparam int KB = 8;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic [7:0]    input_byte_pulsed = '0;
    logic          is_key_pulsed = 1'b0;
    logic          input_byte_pulse = 1'b0;
    logic          err_clear = 1'b0;
    logic [8*KB-1:0] key;
    logic          key_valid;
    logic          key_loaded_pulse;
    logic [7:0]    data_byte;
    logic          data_valid;
    logic          data_ready = 1'b0;
    logic [2:0]    fifo_count;
    logic          fifo_full;
    logic          err_overflow;
    logic          err_no_key;

    data_router #(
        .KEY_BYTES  (KB),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk               (clk),
        .nrst              (nrst),
        .input_byte_pulsed (input_byte_pulsed),
        .is_key_pulsed     (is_key_pulsed),
        .input_byte_pulse  (input_byte_pulse),
        .err_clear         (err_clear),
        .key               (key),
        .key_valid         (key_valid),
        .key_loaded_pulse  (key_loaded_pulse),
        .data_byte         (data_byte),
        .data_valid        (data_valid),
        .data_ready        (data_ready),
        .fifo_count        (fifo_count),
        .fifo_full         (fifo_full),
        .err_overflow      (err_overflow),
        .err_no_key        (err_no_key)
    );

    always #5 clk = ~clk;

    int          tests_run = 0;
    int          failures = 0;
    int          pulse_seen = 0;
    logic        prev_pulse = 1'b0;
    logic [7:0]  exp_data[$];
    logic [63:0] exp_key[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Handshake values seen at the falling edge are the ones the next rising edge uses.
    always @(negedge clk) begin
        if (nrst) begin
            if (data_valid && data_ready) begin
                if (exp_data.size() == 0) begin
                    tests_run++;
                    failures++;
                    $display("FAIL unexpected_data: got %0h expected none", data_byte);
                end else begin
                    chk("data_order", {56'b0, data_byte}, {56'b0, exp_data.pop_front()});
                end
            end
            if (key_loaded_pulse) begin
                pulse_seen++;
                chk("pulse_single_cycle", {63'b0, prev_pulse}, 64'd0);
                chk("pulse_key_valid", {63'b0, key_valid}, 64'd1);
                if (exp_key.size() == 0) begin
                    tests_run++;
                    failures++;
                    $display("FAIL unexpected_key_pulse: got %0h expected none", key);
                end else begin
                    chk("loaded_key", key, exp_key.pop_front());
                end
            end
            prev_pulse = key_loaded_pulse;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic k);
        input_byte_pulsed = b;
        is_key_pulsed     = k;
        input_byte_pulse  = 1'b1;
        tick();
        input_byte_pulse  = 1'b0;
    endtask

    task automatic drain(input int cycles);
        data_ready = 1'b1;
        repeat (cycles) tick();
        data_ready = 1'b0;
    endtask

    task automatic clear_errors();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_key"}, key, 64'd0);
        chk({tag, "_key_valid"}, {63'b0, key_valid}, 64'd0);
        chk({tag, "_pulse"}, {63'b0, key_loaded_pulse}, 64'd0);
        chk({tag, "_data_valid"}, {63'b0, data_valid}, 64'd0);
        chk({tag, "_data_byte"}, {56'b0, data_byte}, 64'd0);
        chk({tag, "_count"}, {61'b0, fifo_count}, 64'd0);
        chk({tag, "_full"}, {63'b0, fifo_full}, 64'd0);
        chk({tag, "_err_ovf"}, {63'b0, err_overflow}, 64'd0);
        chk({tag, "_err_nokey"}, {63'b0, err_no_key}, 64'd0);
    endtask

    initial begin
        repeat (3) tick();
        chk_zero_outputs("reset");
        nrst = 1'b1;
        tick();

        // Data before any key is dropped and flagged
        send(8'hAB, 1'b0);
        chk("nokey_count", {61'b0, fifo_count}, 64'd0);
        chk("nokey_valid", {63'b0, data_valid}, 64'd0);
        chk("nokey_flag", {63'b0, err_no_key}, 64'd1);
        clear_errors();
        chk("nokey_cleared", {63'b0, err_no_key}, 64'd0);

        // Key load 0x11..0x88
        exp_key.push_back(64'h8877665544332211);
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) chk("key_not_valid_before_last", {63'b0, key_valid}, 64'd0);
            send(8'(i * 8'h11), 1'b1);
        end
        tick();
        chk("key_value", key, 64'h8877665544332211);
        chk("key_valid", {63'b0, key_valid}, 64'd1);
        chk("key_pulses_after_load", pulse_seen, 64'd1);

        // Fill and overflow
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_data.push_back(8'(i));
            send(8'(i), 1'b0);
        end
        chk("fill_full", {63'b0, fifo_full}, 64'd1);
        chk("fill_count", {61'b0, fifo_count}, 64'd4);
        chk("fill_ovf", {63'b0, err_overflow}, 64'd1);
        chk("fill_head", {56'b0, data_byte}, 64'h01);
        chk("fill_nokey", {63'b0, err_no_key}, 64'd0);
        clear_errors();
        chk("ovf_cleared", {63'b0, err_overflow}, 64'd0);

        // Full FIFO with simultaneous pop and push
        exp_data.push_back(8'h55);
        data_ready        = 1'b1;
        input_byte_pulsed = 8'h55;
        is_key_pulsed     = 1'b0;
        input_byte_pulse  = 1'b1;
        tick();
        input_byte_pulse  = 1'b0;
        data_ready        = 1'b0;
        chk("popush_count", {61'b0, fifo_count}, 64'd4);
        chk("popush_full", {63'b0, fifo_full}, 64'd1);
        chk("popush_no_ovf", {63'b0, err_overflow}, 64'd0);
        chk("popush_head", {56'b0, data_byte}, 64'h02);
        drain(6);
        chk("drain_count", {61'b0, fifo_count}, 64'd0);
        chk("drain_valid", {63'b0, data_valid}, 64'd0);
        chk("drain_queue", exp_data.size(), 64'd0);

        // Rekey mid-stream
        exp_data.push_back(8'hD1);
        exp_data.push_back(8'hD2);
        send(8'hD1, 1'b0);
        send(8'hD2, 1'b0);
        send(8'hC0, 1'b1);
        chk("rekey_valid_drop", {63'b0, key_valid}, 64'd0);
        chk("rekey_key", key, 64'h88776655443322C0);
        chk("rekey_count", {61'b0, fifo_count}, 64'd2);
        send(8'hE0, 1'b0);
        chk("rekey_nokey", {63'b0, err_no_key}, 64'd1);
        chk("rekey_count_after_drop", {61'b0, fifo_count}, 64'd2);
        drain(4);
        chk("rekey_drained", {61'b0, fifo_count}, 64'd0);
        clear_errors();

        // Complete the new key, queue data, start a partial key, then reset
        exp_key.push_back(64'hC7C6C5C4C3C2C1C0);
        for (int i = 1; i <= 7; i++) send(8'hC0 + 8'(i), 1'b1);
        tick();
        chk("second_key", key, 64'hC7C6C5C4C3C2C1C0);
        send(8'hD3, 1'b0);
        send(8'hD4, 1'b0);
        for (int i = 1; i <= 3; i++) send(8'hF0 + 8'(i), 1'b1);
        chk("pre_reset_count", {61'b0, fifo_count}, 64'd2);
        #2;
        nrst = 1'b0;
        #1;
        chk_zero_outputs("async_reset");
        tick();
        nrst = 1'b1;
        tick();

        // Fresh key loads from slot 0
        exp_key.push_back(64'h2827262524232221);
        for (int i = 1; i <= 8; i++) send(8'h20 + 8'(i), 1'b1);
        tick();
        chk("fresh_key", key, 64'h2827262524232221);
        chk("fresh_key_valid", {63'b0, key_valid}, 64'd1);
        exp_data.push_back(8'h99);
        send(8'h99, 1'b0);
        chk("fresh_data_head", {56'b0, data_byte}, 64'h99);
        drain(3);

        chk("total_key_pulses", pulse_seen, 64'd3);
        chk("final_data_queue", exp_data.size(), 64'd0);
        chk("final_key_queue", exp_key.size(), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

`default_nettype wire
